// File: rtl/cdma_wt_sched_pkg.sv
// Shared defaults and types for the CDMA weight-read scheduler.
// Output-stage states plus the index-width helper used by the top and the picker.
package cdma_wt_sched_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int AW_DEF      = 32;
  localparam int WTW_DEF     = 5;
  localparam int CRW_DEF     = 6;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  // A single requester still needs a 1-bit index port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdma_wt_rr_pick.sv
// Rotating-priority search: first eligible index after cur, wrapping back to cur itself.
// Purely combinational, zero latency; no backpressure of its own.
module cdma_wt_rr_pick
  import cdma_wt_sched_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  localparam int SW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] elig,
  input  logic [SW-1:0]      cur,
  output logic [SW-1:0]      sel,
  output logic               any
);

  logic          found;
  logic [SW-1:0] idx;
  int            pos;

  always_comb begin
    sel   = cur;
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = int'(cur) + k;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end
      idx = SW'(pos);
      if (!found && elig[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  assign any = |elig;

endmodule

// File: rtl/cdma_wt_rd_sched.sv
// Weighted round-robin scheduler of weight-read requests onto one registered read port.
// One-cycle issue latency; stalls on a full output stage or exhausted outstanding credits.
module cdma_wt_rd_sched
  import cdma_wt_sched_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  parameter  int AW      = AW_DEF,
  parameter  int WTW     = WTW_DEF,
  parameter  int CRW     = CRW_DEF,
  localparam int SW      = idx_w(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*AW-1:0]  req_addr,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*WTW-1:0] wt,
  input  logic [CRW-1:0]         cfg_max_outstd,
  output logic                   rd_req_valid,
  output logic [AW-1:0]          rd_req_addr,
  output logic [SW-1:0]          rd_req_src,
  input  logic                   rd_req_ready,
  input  logic                   rsp_done,
  output logic                   sched_idle,
  output logic                   err_underflow
);

  out_state_e     state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [SW-1:0]  src_q, src_d;
  logic [SW-1:0]  cur_q, cur_d;
  logic [WTW-1:0] wt_left_q, wt_left_d;
  logic [CRW-1:0] cnt_q, cnt_d;
  logic           err_q, err_d;

  logic [WTW-1:0]     wt_a   [NUM_REQ];
  logic [AW-1:0]      addr_a [NUM_REQ];
  logic [NUM_REQ-1:0] elig;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign wt_a[g]   = wt[g*WTW +: WTW];
    assign addr_a[g] = req_addr[g*AW +: AW];
    assign elig[g]   = req_valid[g] && (wt_a[g] != '0);
  end

  logic [SW-1:0] pick_sel;
  logic          pick_any;

  cdma_wt_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .elig (elig),
    .cur  (cur_q),
    .sel  (pick_sel),
    .any  (pick_any)
  );

  logic          slot_open;
  logic          credit_ok;
  logic          keep_cur;
  logic          hs;
  logic          underflow;
  logic [SW-1:0] sel;

  always_comb begin
    slot_open = (state_q == EMPTY) || rd_req_ready;
    credit_ok = cnt_q < cfg_max_outstd;
    // The current owner keeps the grant while it has weight left and still asks.
    keep_cur  = (wt_left_q != '0) && elig[cur_q];
    sel       = keep_cur ? cur_q : pick_sel;
    hs        = slot_open && credit_ok && (keep_cur || pick_any);
    underflow = rsp_done && (cnt_q == '0);

    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = hs && (sel == SW'(i));
    end

    state_d = state_q;
    addr_d  = addr_q;
    src_d   = src_q;
    if (hs) begin
      state_d = FULL;
      addr_d  = addr_a[sel];
      src_d   = sel;
    end else if ((state_q == FULL) && rd_req_ready) begin
      state_d = EMPTY;
    end

    cur_d     = cur_q;
    wt_left_d = wt_left_q;
    if (hs) begin
      if ((sel != cur_q) || (wt_left_q == '0)) begin
        cur_d     = sel;
        wt_left_d = wt_a[sel] - WTW'(1);
      end else begin
        wt_left_d = wt_left_q - WTW'(1);
      end
    end

    cnt_d = cnt_q;
    if (hs && !rsp_done) begin
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CRW'(1);
      end
    end else if (!hs && rsp_done && !underflow) begin
      cnt_d = cnt_q - CRW'(1);
    end

    err_d = err_q || underflow;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= EMPTY;
      addr_q    <= '0;
      src_q     <= '0;
      cur_q     <= SW'(NUM_REQ - 1);
      wt_left_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      src_q     <= src_d;
      cur_q     <= cur_d;
      wt_left_q <= wt_left_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign rd_req_valid  = (state_q == FULL);
  assign rd_req_addr   = addr_q;
  assign rd_req_src    = src_q;
  assign sched_idle    = (state_q == EMPTY) && (cnt_q == '0);
  assign err_underflow = err_q;

endmodule

// File: tb/tb_cdma_wt_rd_sched.sv
// Directed bench for cdma_wt_rd_sched: expected (src, addr) pushed when requests are driven,
// popped and compared when the read port transfers; plus direct flag and credit checks.
module tb_cdma_wt_rd_sched;

  typedef struct {
    logic [1:0]  src;
    logic [31:0] addr;
  } exp_t;

  logic         clk;
  logic         reset;
  logic [3:0]   req_valid;
  logic [127:0] req_addr;
  logic [3:0]   req_ready;
  logic [19:0]  wt;
  logic [5:0]   cfg_max_outstd;
  logic         rd_req_valid;
  logic [31:0]  rd_req_addr;
  logic [1:0]   rd_req_src;
  logic         rd_req_ready;
  logic         rsp_done;
  logic         sched_idle;
  logic         err_underflow;

  int   n_assert;
  int   n_fail;
  int   hs_cnt;
  logic [3:0] grant_mask;
  exp_t sbq[$];

  cdma_wt_rd_sched dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_ready      (req_ready),
    .wt             (wt),
    .cfg_max_outstd (cfg_max_outstd),
    .rd_req_valid   (rd_req_valid),
    .rd_req_addr    (rd_req_addr),
    .rd_req_src     (rd_req_src),
    .rd_req_ready   (rd_req_ready),
    .rsp_done       (rsp_done),
    .sched_idle     (sched_idle),
    .err_underflow  (err_underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] addr_of(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0000_0104;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expd);
    n_assert++;
    assert (obs === expd) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expd);
    end
  endtask

  task automatic push_exp(input int s);
    exp_t e;
    e.src  = 2'(s);
    e.addr = addr_of(s);
    sbq.push_back(e);
  endtask

  task automatic set_wt(input int w0, input int w1, input int w2, input int w3);
    wt = {5'(w3), 5'(w2), 5'(w1), 5'(w0)};
  endtask

  // Called at a falling edge with inputs already applied: sample, then move to the next falling edge.
  task automatic tick();
    exp_t e;
    #1;
    if (!reset) begin
      if (|(req_valid & req_ready)) begin
        hs_cnt++;
        grant_mask = grant_mask | (req_valid & req_ready);
      end
      if (rd_req_valid && rd_req_ready) begin
        chk("sb_has_entry", 64'(sbq.size() != 0), 64'd1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("sb_src", 64'(rd_req_src), 64'(e.src));
          chk("sb_addr", 64'(rd_req_addr), 64'(e.addr));
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    req_valid    = '0;
    rsp_done     = 1'b0;
    rd_req_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    sbq.delete();
  endtask

  initial begin
    int seq1[5];
    int seq2[8];
    int hs0;

    seq1 = '{0, 1, 2, 3, 0};
    seq2 = '{0, 0, 0, 1, 0, 0, 0, 1};
    n_assert = 0;
    n_fail = 0;
    hs_cnt = 0;
    grant_mask = '0;
    reset = 1'b1;
    req_valid = '0;
    rsp_done = 1'b0;
    rd_req_ready = 1'b0;
    cfg_max_outstd = 6'd63;
    set_wt(1, 1, 1, 1);
    for (int i = 0; i < 4; i++) begin
      req_addr[i*32 +: 32] = addr_of(i);
    end
    @(negedge clk);

    // Reset state
    do_reset();
    chk("rst_valid", 64'(rd_req_valid), 64'd0);
    chk("rst_addr", 64'(rd_req_addr), 64'd0);
    chk("rst_src", 64'(rd_req_src), 64'd0);
    chk("rst_idle", 64'(sched_idle), 64'd1);
    chk("rst_err", 64'(err_underflow), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);

    // Equal weights: plain round robin starting at requester 0
    set_wt(1, 1, 1, 1);
    cfg_max_outstd = 6'd63;
    rd_req_ready = 1'b1;
    foreach (seq1[k]) push_exp(seq1[k]);
    hs0 = hs_cnt;
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("s1_valid_run", 64'(rd_req_valid), 64'd1);
    end
    req_valid = '0;
    tick();
    tick();
    chk("s1_issues", 64'(hs_cnt - hs0), 64'd5);
    chk("s1_drained", 64'(sbq.size()), 64'd0);
    chk("s1_busy", 64'(sched_idle), 64'd0);
    rsp_done = 1'b1;
    repeat (5) tick();
    rsp_done = 1'b0;
    tick();
    chk("s1_idle", 64'(sched_idle), 64'd1);
    chk("s1_no_err", 64'(err_underflow), 64'd0);

    // Weighted 3:1 with zero-weight requesters also asking
    do_reset();
    set_wt(3, 1, 0, 0);
    rd_req_ready = 1'b1;
    foreach (seq2[k]) push_exp(seq2[k]);
    grant_mask = '0;
    hs0 = hs_cnt;
    req_valid = 4'hF;
    repeat (8) tick();
    req_valid = '0;
    tick();
    tick();
    chk("s2_issues", 64'(hs_cnt - hs0), 64'd8);
    chk("s2_no_zero_wt", 64'(grant_mask[3:2]), 64'd0);
    chk("s2_drained", 64'(sbq.size()), 64'd0);

    // Credit limit of 2, then one returned credit
    do_reset();
    set_wt(1, 1, 1, 1);
    cfg_max_outstd = 6'd2;
    rd_req_ready = 1'b1;
    push_exp(0);
    push_exp(0);
    hs0 = hs_cnt;
    req_valid = 4'b0001;
    repeat (6) tick();
    chk("s3_two_issues", 64'(hs_cnt - hs0), 64'd2);
    chk("s3_blocked", 64'(req_ready), 64'd0);
    rsp_done = 1'b1;
    push_exp(0);
    tick();
    rsp_done = 1'b0;
    repeat (5) tick();
    chk("s3_one_more", 64'(hs_cnt - hs0), 64'd3);
    chk("s3_blocked_again", 64'(req_ready), 64'd0);
    req_valid = '0;
    tick();
    chk("s3_drained", 64'(sbq.size()), 64'd0);

    // Downstream stall, then accept and new handshake in the same cycle
    do_reset();
    set_wt(1, 1, 1, 1);
    cfg_max_outstd = 6'd63;
    rd_req_ready = 1'b0;
    req_valid = 4'b0011;
    push_exp(0);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("s4_hold_valid", 64'(rd_req_valid), 64'd1);
      chk("s4_hold_src", 64'(rd_req_src), 64'd0);
      chk("s4_hold_addr", 64'(rd_req_addr), 64'(addr_of(0)));
      chk("s4_hold_rdy", 64'(req_ready), 64'd0);
      tick();
    end
    rd_req_ready = 1'b1;
    #1;
    chk("s4_release_rdy", 64'(req_ready), 64'b0010);
    push_exp(1);
    tick();
    chk("s4_stay_full", 64'(rd_req_valid), 64'd1);
    chk("s4_new_src", 64'(rd_req_src), 64'd1);
    req_valid = '0;
    tick();
    chk("s4_empty", 64'(rd_req_valid), 64'd0);
    chk("s4_drained", 64'(sbq.size()), 64'd0);

    // Completion with nothing outstanding
    do_reset();
    rsp_done = 1'b1;
    tick();
    rsp_done = 1'b0;
    chk("s5_err_set", 64'(err_underflow), 64'd1);
    chk("s5_idle", 64'(sched_idle), 64'd1);
    repeat (3) tick();
    chk("s5_err_sticky", 64'(err_underflow), 64'd1);
    cfg_max_outstd = 6'd1;
    set_wt(1, 1, 1, 1);
    rd_req_ready = 1'b1;
    push_exp(0);
    hs0 = hs_cnt;
    req_valid = 4'b0001;
    repeat (4) tick();
    chk("s5_count_zero", 64'(hs_cnt - hs0), 64'd1);
    req_valid = '0;
    tick();
    chk("s5_err_still", 64'(err_underflow), 64'd1);

    // Reset while FULL with three reads outstanding
    do_reset();
    chk("s6_err_cleared", 64'(err_underflow), 64'd0);
    cfg_max_outstd = 6'd63;
    set_wt(1, 1, 1, 1);
    rd_req_ready = 1'b1;
    push_exp(0);
    push_exp(1);
    push_exp(2);
    req_valid = 4'hF;
    repeat (3) tick();
    req_valid = '0;
    rd_req_ready = 1'b0;
    tick();
    chk("s6_full", 64'(rd_req_valid), 64'd1);
    chk("s6_full_src", 64'(rd_req_src), 64'd2);
    chk("s6_busy", 64'(sched_idle), 64'd0);
    reset = 1'b1;
    tick();
    chk("s6_rst_valid", 64'(rd_req_valid), 64'd0);
    chk("s6_rst_idle", 64'(sched_idle), 64'd1);
    sbq.delete();
    reset = 1'b0;
    req_valid = 4'hF;
    rd_req_ready = 1'b1;
    #1;
    chk("s6_first_grant", 64'(req_ready), 64'b0001);
    push_exp(0);
    tick();
    chk("s6_first_src", 64'(rd_req_src), 64'd0);
    req_valid = '0;
    tick();
    tick();
    chk("final_drained", 64'(sbq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cdma_wt_rd_sched.md
CDMA_WT_RD_SCHED -- requirements
Module: cdma_wt_rd_sched

Interface
REQ-001 Parameter NUM_REQ SHALL be: default 4; number of weight-read requesters.
REQ-002 Parameter AW SHALL be: default 32; request address width.
REQ-003 Parameter WTW SHALL be: default 5; per-requester weight width.
REQ-004 Parameter CRW SHALL be: default 6; outstanding-credit counter width.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 Port clk SHALL be: input, 1, sole clock.
REQ-007 Port reset SHALL be: input, 1, synchronous active-high reset.
REQ-008 Port req_valid SHALL be: input, NUM_REQ, per-requester request valid.
REQ-009 Port req_addr SHALL be: input, NUM_REQ*AW, packed addresses; requester i uses slice i.
REQ-010 Port req_ready SHALL be: output, NUM_REQ, per-requester accept.
REQ-011 Port wt SHALL be: input, NUM_REQ*WTW, packed WRR weights; 0 means disabled.
REQ-012 Port cfg_max_outstd SHALL be: input, CRW, outstanding-read limit.
REQ-013 Port rd_req_valid SHALL be: output, 1, downstream read request valid.
REQ-014 Port rd_req_addr SHALL be: output, AW, registered address.
REQ-015 Port rd_req_src SHALL be: output, log2(NUM_REQ), source requester index.
REQ-016 Port rd_req_ready SHALL be: input, 1, downstream accept.
REQ-017 Port rsp_done SHALL be: input, 1, one-cycle pulse per completed read; returns one credit.
REQ-018 Port sched_idle SHALL be: output, 1, high when the output is empty and outstd_cnt==0.
REQ-019 Port err_underflow SHALL be: output, 1, sticky flag for rsp_done received with outstd_cnt==0.

Function
REQ-020 Requester i SHALL be eligible when req_valid[i]==1 and wt slice i != 0.
REQ-021 Output stage SHALL be a 2-state FSM: EMPTY -> FULL on upstream handshake; FULL -> EMPTY on rd_req_ready with no new handshake; FULL -> FULL when accept and new handshake coincide.
REQ-022 Slot SHALL be open when state==EMPTY or (rd_req_valid and rd_req_ready).
REQ-023 Credit SHALL be available when outstd_cnt < cfg_max_outstd; cfg_max_outstd==0 blocks all issue.
REQ-024 req_ready SHALL be one-hot or zero: only bit sel asserted, only when slot open, credit available, and sel eligible; req_ready is combinational.
REQ-025 Selection: if wt_left==0 or cur not eligible, sel SHALL be the first eligible index scanning cur+1, cur+2, ..., cur modulo NUM_REQ; otherwise sel=cur.
REQ-026 On handshake with sel!=cur or wt_left==0, the block SHALL set cur=sel and wt_left=wt[sel]-1; otherwise wt_left SHALL decrement by 1.
REQ-027 With no handshake, cur and wt_left SHALL hold.
REQ-028 A handshake in cycle N SHALL present rd_req_valid/addr/src in cycle N+1; fields SHALL be stable while valid and not ready.
REQ-029 outstd_cnt SHALL increment on upstream handshake and decrement on rsp_done; when both occur it SHALL be unchanged; it SHALL never wrap.
REQ-030 rsp_done with outstd_cnt==0 SHALL leave the count at 0 and set err_underflow.
REQ-031 Weight changes SHALL take effect only at the next reload of wt_left.
REQ-032 Lowering cfg_max_outstd below outstd_cnt SHALL stall issue only; no drop or flush.

Reset
REQ-033 Under reset the block SHALL set: state=EMPTY, rd_req_valid=0, rd_req_addr=0, rd_req_src=0, outstd_cnt=0, wt_left=0, cur=NUM_REQ-1 (first grant goes to requester 0), err_underflow=0, sched_idle=1.
REQ-034 Reset asserted mid-transfer SHALL discard the pending output and all credits at the next edge.

Structure
REQ-035 Package cdma_wt_sched_pkg SHALL hold NUM_REQ, AW, WTW and CRW defaults plus the EMPTY/FULL state enum.
REQ-036 Rotating-priority search SHALL be the sub-module cdma_wt_rr_pick (inputs: eligible vector, cur; output: sel, any).

Verification
REQ-037 Bench SHALL cover: wt={1,1,1,1}, all valid, max_outstd=63, ready=1 -> src sequence 0,1,2,3,0 on consecutive cycles.
REQ-038 Bench SHALL cover: wt={3,1,0,0} (req0=3, req1=1), both valid -> src 0,0,0,1,0,0,0,1; requesters 2 and 3 never granted.
REQ-039 Bench SHALL cover: max_outstd=2, no rsp_done -> exactly 2 issues, then req_ready=0; one rsp_done -> exactly 1 further issue.
REQ-040 Bench SHALL cover: rd_req_ready=0 for 5 cycles -> addr/src stable, req_ready=0; at release, accept and new handshake in the same cycle -> FSM stays FULL.
REQ-041 Bench SHALL cover: rsp_done with count 0 -> err_underflow=1 and stays set until reset; count stays 0.
REQ-042 Bench SHALL cover: reset asserted while FULL with count 3 -> next cycle rd_req_valid=0, sched_idle=1, first grant goes to requester 0.
